// File: rtl/llr_input_loader_pkg.sv
// Shared constants for the SC polar decoder front end: decoder FSM state codes,
// frame geometry and the loader FSM state type.
package llr_input_loader_pkg;

  localparam int STATE_WIDTH = 9;

  localparam logic [STATE_WIDTH-1:0] INPUT_STATE             = 9'd2;
  localparam logic [STATE_WIDTH-1:0] LLR_READ_STATE          = 9'd4;
  localparam logic [STATE_WIDTH-1:0] LLR_CAL_AND_STORE_STATE = 9'd8;

  localparam int IN_WIDTH   = 16;
  localparam int FRAC_SHIFT = 4;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 10;
  localparam int CODE_LEN   = 1024;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_FLUSH,
    LD_DONE,
    LD_HOLD
  } loader_fsm_e;

endpackage

// File: rtl/llr_input_loader_if.sv
// Channel LLR sample stream (valid/ready with end-of-frame marker).
// The master side produces samples and the slave side (the loader) accepts them.
interface llr_input_loader_if #(
  parameter int IN_WIDTH = llr_input_loader_pkg::IN_WIDTH
) ();

  logic signed [IN_WIDTH-1:0] s_data;
  logic                       s_valid;
  logic                       s_last;
  logic                       s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/llr_input_loader_quantizer.sv
// Combinational LLR quantizer: round-half-up, arithmetic shift by FRAC_SHIFT,
// then symmetric saturation so the most negative code is never produced.
module llr_input_loader_quantizer #(
  parameter int IN_WIDTH   = 16,
  parameter int FRAC_SHIFT = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [IN_WIDTH-1:0]   din_i,
  output logic signed [DATA_WIDTH-1:0] dout_o
);

  localparam int HALF_I = 1 << (FRAC_SHIFT - 1);
  localparam int SAT_I  = (1 << (DATA_WIDTH - 1)) - 1;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  function automatic logic signed [IN_WIDTH:0] round_shift(input logic signed [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] half;
    ext  = {x[IN_WIDTH-1], x};
    half = (IN_WIDTH+1)'(HALF_I);
    ext  = ext + half;
    return ext >>> FRAC_SHIFT;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_sym(input logic signed [IN_WIDTH:0] v);
    logic signed [IN_WIDTH:0] hi;
    logic signed [IN_WIDTH:0] lo;
    hi = (IN_WIDTH+1)'(SAT_I);
    lo = -hi;
    if (v > hi) begin
      return DATA_WIDTH'(SAT_I);
    end else if (v < lo) begin
      return DATA_WIDTH'(-SAT_I);
    end else begin
      return v[DATA_WIDTH-1:0];
    end
  endfunction

  always_comb begin
    dout_o = sat_sym(round_shift(din_i));
  end

endmodule

// File: rtl/llr_input_loader.sv
// Loads one frame of quantized channel LLRs into the LLR init BRAM and pulses input_fin when done.
// Build option BIT_REVERSE_LOAD_EN: store sample k at the bit-reversed address of k.
module llr_input_loader #(
  parameter int                      STATE_WIDTH = llr_input_loader_pkg::STATE_WIDTH,
  parameter logic [STATE_WIDTH-1:0]  INPUT_STATE = llr_input_loader_pkg::INPUT_STATE,
  parameter int                      IN_WIDTH    = llr_input_loader_pkg::IN_WIDTH,
  parameter int                      FRAC_SHIFT  = llr_input_loader_pkg::FRAC_SHIFT,
  parameter int                      DATA_WIDTH  = llr_input_loader_pkg::DATA_WIDTH,
  parameter int                      ADDR_WIDTH  = llr_input_loader_pkg::ADDR_WIDTH,
  parameter int                      CODE_LEN    = llr_input_loader_pkg::CODE_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STATE_WIDTH-1:0] state,
  llr_input_loader_if.slave      s_if,
  output logic [ADDR_WIDTH-1:0]  addr_a_to_llr_init_bram,
  output logic [DATA_WIDTH-1:0]  data_a_to_llr_init_bram,
  output logic                   enable_to_llr_init_bram,
  output logic                   write_enable_to_llr_init_bram,
  output logic                   input_fin,
  output logic                   frame_err
);

  import llr_input_loader_pkg::*;

  localparam int LOG2_LEN = $clog2(CODE_LEN);

  loader_fsm_e fsm_q, fsm_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic signed [DATA_WIDTH-1:0] data_q;

  logic                  in_input;
  logic                  hs;
  logic                  last_sample;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic signed [DATA_WIDTH-1:0] q_data;

  assign in_input    = (state == INPUT_STATE);
  assign s_if.s_ready = (fsm_q == LD_LOAD) && in_input;
  assign hs          = s_if.s_valid && s_if.s_ready;
  assign last_sample = (cnt_q == ADDR_WIDTH'(CODE_LEN - 1));

  llr_input_loader_quantizer #(
    .IN_WIDTH   (IN_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_quant (
    .din_i  (s_if.s_data),
    .dout_o (q_data)
  );

`ifdef BIT_REVERSE_LOAD_EN
  function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] v);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2_LEN; i++) begin
      r[i] = v[LOG2_LEN-1-i];
    end
    return r;
  endfunction

  assign wr_addr = bit_reverse(cnt_q);
`else
  assign wr_addr = cnt_q;
`endif

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (fsm_q)
      LD_IDLE: begin
        if (in_input) begin
          fsm_d = LD_LOAD;
          cnt_d = '0;
        end
      end
      LD_LOAD: begin
        if (!in_input) begin
          // Abort: drop the partial frame; any write already registered still lands.
          fsm_d = LD_IDLE;
          cnt_d = '0;
          err_d = 1'b1;
        end else if (hs) begin
          if (cnt_q == '0) begin
            err_d = 1'b0;
          end
          if (s_if.s_last != last_sample) begin
            err_d = 1'b1;
          end
          if (last_sample) begin
            fsm_d = LD_FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LD_FLUSH: fsm_d = LD_DONE;
      LD_DONE:  fsm_d = LD_HOLD;
      LD_HOLD: begin
        if (!in_input) begin
          fsm_d = LD_IDLE;
        end
      end
      default: fsm_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q <= LD_IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Write stage: handshake in cycle t appears on the BRAM port in cycle t+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q <= hs;
      if (hs) begin
        addr_q <= wr_addr;
        data_q <= q_data;
      end
    end
  end

  assign addr_a_to_llr_init_bram       = addr_q;
  assign data_a_to_llr_init_bram       = data_q;
  assign enable_to_llr_init_bram       = wr_q;
  assign write_enable_to_llr_init_bram = wr_q;
  assign input_fin                     = (fsm_q == LD_DONE);
  assign frame_err                     = err_q;

endmodule
